// File: rtl/mux_bus_pkg.sv
// Shared types and defaults for the multiplexed address/data bus sequencer.
package mux_bus_pkg;

   localparam int ADDR_BYTES_DEF = 2;
   localparam int WAIT_W_DEF     = 3;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      ACCESS,
      WR_HOLD
   } state_t;

endpackage

// File: rtl/mux_bus_shadow.sv
// Shadow copies of the upper address bytes already latched on the bus, with
// per-byte valid flags and a miss vector (bit 0 is never a miss).
module mux_bus_shadow
   import mux_bus_pkg::*;
#(
   parameter int  ADDR_BYTES = ADDR_BYTES_DEF,
   localparam int K_W        = $clog2(ADDR_BYTES)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [8*(ADDR_BYTES-1)-1:0]   addr_hi,
   output logic [ADDR_BYTES-1:0]         miss,
   input  logic                          upd_en,
   input  logic [K_W-1:0]                upd_idx,
   input  logic [7:0]                    upd_byte
);

   assign miss[0] = 1'b0;

   for (genvar k = 1; k < ADDR_BYTES; k++) begin : g_byte
      logic [7:0] sh;
      logic       vld;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sh  <= '0;
            vld <= 1'b0;
         end else if (upd_en && upd_idx == K_W'(k)) begin
            sh  <= upd_byte;
            vld <= 1'b1;
         end
      end

      assign miss[k] = !vld || (sh != addr_hi[8*(k-1) +: 8]);
   end

endmodule

// File: rtl/mux_bus_seq.sv
// Multiplexed-bus access sequencer: upper address bytes (only when changed),
// low byte, strobed access, optional write hold. Wait states need MUXBUS_WAIT_EN.
module mux_bus_seq
   import mux_bus_pkg::*;
#(
   parameter int  ADDR_BYTES = ADDR_BYTES_DEF,
   parameter int  WAIT_W     = WAIT_W_DEF,
   localparam int K_W        = $clog2(ADDR_BYTES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic                    req_io,
   input  logic [8*ADDR_BYTES-1:0] req_addr,
   input  logic [7:0]              req_wdata,
`ifdef MUXBUS_WAIT_EN
   input  logic [WAIT_W-1:0]       wait_states,
`endif
   output logic                    rsp_valid,
   output logic [7:0]              rsp_rdata,
   output logic [7:0]              bus_out,
   output logic                    bus_oe,
   input  logic [7:0]              bus_in,
   output logic [ADDR_BYTES-1:0]   le,
   output logic                    OEb,
   output logic                    WEb,
   output logic                    IOC
);

   state_t                  state;
   logic [8*ADDR_BYTES-1:0] addr_q;
   logic [7:0]              wdata_q;
   logic                    we_q;
   logic                    io_q;
   logic [WAIT_W-1:0]       wcnt;
   logic [WAIT_W-1:0]       wait_in;
   logic [ADDR_BYTES-1:0]   pend;
   logic [ADDR_BYTES-1:0]   miss;
   logic [ADDR_BYTES-1:0]   sel_mask;
   logic [K_W-1:0]          cur_k;
   logic [K_W-1:0]          nxt_k;
   logic [8*ADDR_BYTES-1:0] hi_src;
   logic [7:0]              hi_byte;

`ifdef MUXBUS_WAIT_EN
   assign wait_in = wait_states;
`else
   assign wait_in = '0;
`endif

   mux_bus_shadow #(.ADDR_BYTES(ADDR_BYTES)) u_shadow (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr_hi  (req_addr[8*ADDR_BYTES-1:8]),
      .miss     (miss),
      .upd_en   (state == ADDR_HI),
      .upd_idx  (cur_k),
      .upd_byte (addr_q[8*cur_k +: 8])
   );

   // In IDLE the pending set comes from the live request; in ADDR_HI it is
   // what remains after the byte being latched this cycle.
   always_comb begin
      sel_mask = (state == IDLE) ? (req_io ? '0 : miss)
                                 : (pend & ~(ADDR_BYTES'(1) << cur_k));
      nxt_k = '0;
      for (int k = 1; k < ADDR_BYTES; k++)
         if (sel_mask[k]) nxt_k = K_W'(k);
      hi_src  = (state == IDLE) ? req_addr : addr_q;
      hi_byte = hi_src[8*nxt_k +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         bus_out   <= '0;
         bus_oe    <= 1'b0;
         le        <= '0;
         OEb       <= 1'b1;
         WEb       <= 1'b1;
         IOC       <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         io_q      <= 1'b0;
         wcnt      <= '0;
         pend      <= '0;
         cur_k     <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               addr_q    <= req_addr;
               wdata_q   <= req_wdata;
               we_q      <= req_we;
               io_q      <= req_io;
               wcnt      <= wait_in;
               req_ready <= 1'b0;
               bus_oe    <= 1'b1;
               pend      <= sel_mask;
               cur_k     <= nxt_k;
               if (|sel_mask) begin
                  state   <= ADDR_HI;
                  le      <= ADDR_BYTES'(1) << nxt_k;
                  bus_out <= hi_byte;
               end else begin
                  state   <= ADDR_LO;
                  le      <= ADDR_BYTES'(1);
                  bus_out <= req_addr[7:0];
               end
            end
            ADDR_HI: begin
               pend  <= sel_mask;
               cur_k <= nxt_k;
               if (|sel_mask) begin
                  le      <= ADDR_BYTES'(1) << nxt_k;
                  bus_out <= hi_byte;
               end else begin
                  state   <= ADDR_LO;
                  le      <= ADDR_BYTES'(1);
                  bus_out <= addr_q[7:0];
               end
            end
            ADDR_LO: begin
               state <= ACCESS;
               le    <= '0;
               IOC   <= io_q;
               if (we_q) begin
                  WEb     <= 1'b0;
                  bus_out <= wdata_q;
               end else begin
                  OEb     <= 1'b0;
                  bus_oe  <= 1'b0;
                  bus_out <= '0;
               end
            end
            ACCESS: begin
               if (wcnt != '0) begin
                  wcnt <= wcnt - WAIT_W'(1);
               end else begin
                  IOC <= 1'b0;
                  if (we_q) begin
                     state <= WR_HOLD;
                     WEb   <= 1'b1;
                  end else begin
                     state     <= IDLE;
                     OEb       <= 1'b1;
                     rsp_rdata <= bus_in;
                     rsp_valid <= 1'b1;
                     req_ready <= 1'b1;
                  end
               end
            end
            WR_HOLD: begin
               state     <= IDLE;
               bus_oe    <= 1'b0;
               bus_out   <= '0;
               rsp_valid <= 1'b1;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_bus_seq.sv
// Directed bench for mux_bus_seq with a read-data scoreboard and per-cycle
// traces; the wait-state step is built only with MUXBUS_WAIT_EN.
module tb_mux_bus_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_io;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
`ifdef MUXBUS_WAIT_EN
   logic [2:0]  wait_states;
`endif
   logic        rsp_valid;
   logic [7:0]  rsp_rdata, bus_out, bus_in;
   logic        bus_oe, OEb, WEb, IOC;
   logic [1:0]  le;

   int checks = 0;
   int errors = 0;

   typedef struct {logic we; logic [7:0] rdata;} exp_t;
   exp_t sb_q[$];

   logic [1:0] tr_le  [1:24];
   logic [7:0] tr_bo  [1:24];
   logic       tr_oe  [1:24];
   logic       tr_oeb [1:24];
   logic       tr_web [1:24];
   logic       tr_ioc [1:24];
   int         lat;

   localparam logic [23:0] RST_EXP = {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};

   mux_bus_seq #(.ADDR_BYTES(2), .WAIT_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_io      (req_io),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
`ifdef MUXBUS_WAIT_EN
      .wait_states (wait_states),
`endif
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .bus_out     (bus_out),
      .bus_oe      (bus_oe),
      .bus_in      (bus_in),
      .le          (le),
      .OEb         (OEb),
      .WEb         (WEb),
      .IOC         (IOC)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] rst_vec();
      return {req_ready, rsp_valid, rsp_rdata, bus_out, bus_oe, le, OEb, WEb, IOC};
   endfunction

   function automatic int count_le1();
      int s = 0;
      for (int c = 1; c <= lat && c <= 24; c++) s += int'(tr_le[c][1]);
      return s;
   endfunction

   // Strobe/latch sanity on every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         assert (!(OEb == 1'b0 && WEb == 1'b0) && $onehot0(le)) else begin
            errors++;
            $error("FAIL strobe_invariant observed OEb=%0b WEb=%0b le=%0b", OEb, WEb, le);
         end
      end
   end

   // Issue one request from a negedge, trace each cycle until rsp_valid.
   // bus_in carries bin only during the final OEb-low cycle.
   task automatic do_req(input logic we, input logic io, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] bin, input int wst);
      int   n = 0;
      int   oeb_cnt = 0;
      exp_t e;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(n < 50), 1);
      req_valid = 1'b1;
      req_we    = we;
      req_io    = io;
      req_addr  = addr;
      req_wdata = wd;
      bus_in    = ~bin;
`ifdef MUXBUS_WAIT_EN
      wait_states = 3'(wst);
`endif
      e.we = we;
      e.rdata = bin;
      sb_q.push_back(e);
      for (int c = 1; c <= 24; c++) begin
         tr_le[c] = '0; tr_bo[c] = '0; tr_oe[c] = 1'b0;
         tr_oeb[c] = 1'b1; tr_web[c] = 1'b1; tr_ioc[c] = 1'b0;
      end
      lat = -1;
      @(posedge clk);
      for (int c = 1; c <= 24 && lat < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b0;
            req_we    = ~we;
            req_io    = ~io;
            req_addr  = ~addr;
            req_wdata = ~wd;
`ifdef MUXBUS_WAIT_EN
            wait_states = 3'd0;
`endif
         end
         tr_le[c] = le; tr_bo[c] = bus_out; tr_oe[c] = bus_oe;
         tr_oeb[c] = OEb; tr_web[c] = WEb; tr_ioc[c] = IOC;
         if (!OEb) oeb_cnt++;
         bus_in = (!OEb && oeb_cnt == wst + 1) ? bin : ~bin;
         if (rsp_valid) begin
            lat = c;
            chk("sb_nonempty", sb_q.size(), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               if (!e.we) chk("rsp_rdata", rsp_rdata, e.rdata);
            end
         end
      end
      chk("rsp_timeout", 32'(lat > 0), 1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_io = 1'b0;
      req_addr = '0; req_wdata = '0; bus_in = '0;
`ifdef MUXBUS_WAIT_EN
      wait_states = '0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_outputs", rst_vec(), RST_EXP);
      rst_n = 1'b1;
      @(negedge clk);

      // Cold read: high byte latched first
      do_req(1'b0, 1'b0, 16'h0100, 8'h00, 8'h65, 0);
      chk("s1_lat", lat, 4);
      chk("s1_c1_le", tr_le[1], 2'b10);
      chk("s1_c1_bus", tr_bo[1], 8'h01);
      chk("s1_c1_oe", tr_oe[1], 1);
      chk("s1_c2_le", tr_le[2], 2'b01);
      chk("s1_c2_bus", tr_bo[2], 8'h00);
      chk("s1_oeb", {tr_oeb[1], tr_oeb[2], tr_oeb[3], tr_oeb[4]}, 4'b1101);
      chk("s1_acc_oe", tr_oe[3], 0);
      chk("s1_acc_le", tr_le[3], 2'b00);

      // Same high byte: shadow hit
      do_req(1'b0, 1'b0, 16'h0101, 8'h00, 8'h3C, 0);
      chk("s2_lat", lat, 3);
      chk("s2_no_le_hi", count_le1(), 0);
      chk("s2_c1_bus", tr_bo[1], 8'h01);

      // I/O cycle: no high byte, shadow untouched
      do_req(1'b0, 1'b1, 16'h0012, 8'h00, 8'hC3, 0);
      chk("io_lat", lat, 3);
      chk("io_no_le_hi", count_le1(), 0);
      chk("io_ioc", {tr_ioc[1], tr_ioc[2], tr_ioc[3]}, 3'b010);
      chk("io_c1_bus", tr_bo[1], 8'h12);
      do_req(1'b0, 1'b0, 16'h0105, 8'h00, 8'h5A, 0);
      chk("after_io_lat", lat, 3);
      chk("after_io_no_le_hi", count_le1(), 0);

      // Write with new high byte
      do_req(1'b1, 1'b0, 16'hF733, 8'hA5, 8'h00, 0);
      chk("wr_lat", lat, 5);
      chk("wr_c1", {tr_le[1], tr_bo[1]}, {2'b10, 8'hF7});
      chk("wr_c2", {tr_le[2], tr_bo[2]}, {2'b01, 8'h33});
      chk("wr_access", {tr_web[3], tr_oe[3], tr_bo[3], tr_le[3]}, {1'b0, 1'b1, 8'hA5, 2'b00});
      chk("wr_hold", {tr_web[4], tr_oe[4], tr_bo[4]}, {1'b1, 1'b1, 8'hA5});
      chk("wr_oeb_high", {tr_oeb[1], tr_oeb[2], tr_oeb[3], tr_oeb[4], tr_oeb[5]}, 5'b11111);

`ifdef MUXBUS_WAIT_EN
      do_req(1'b0, 1'b0, 16'hF707, 8'h00, 8'h99, 3);
      chk("ws_lat", lat, 6);
      chk("ws_oeb", {tr_oeb[1], tr_oeb[2], tr_oeb[3], tr_oeb[4], tr_oeb[5], tr_oeb[6]}, 6'b100001);
      chk("ws_no_le_hi", count_le1(), 0);
`endif

      // Reset during the access of a write
      req_valid = 1'b1; req_we = 1'b1; req_io = 1'b0;
      req_addr = 16'h2233; req_wdata = 8'h5A;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         req_valid = 1'b0;
         n++;
      end while (WEb && n < 10);
      chk("mid_web_low", WEb, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs", rst_vec(), RST_EXP);
      repeat (2) begin
         @(negedge clk);
         chk("mid_no_rsp", rsp_valid, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_no_rsp", rsp_valid, 0);

      do_req(1'b0, 1'b0, 16'h2205, 8'h00, 8'h77, 0);
      chk("relatch_lat", lat, 4);
      chk("relatch_c1", {tr_le[1], tr_bo[1]}, {2'b10, 8'h22});

      chk("final_sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
